// File: rtl/press_classifier_pkg.sv
// rtl/press_classifier_pkg.sv - shared state encoding and event codes for press_classifier
package press_classifier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    GAP   = 2'd2,
    HELD2 = 2'd3
  } state_e;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - microsecond prescaler with synchronous clear and tick output
module us_tick_gen #(
  parameter int unsigned CNT_1US = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CNT_1US > 1) ? $clog2(CNT_1US) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // tick on the last count; clear restarts the microsecond from zero
  always_comb begin
    tick  = (cnt_q == CW'(CNT_1US - 1));
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // prescaler count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classify qualified presses as short/long/double; PRESS_CLASSIFIER_OVF_EN adds sticky drop flag
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned CNT_1US    = 100,
  parameter int unsigned LONG_US    = 1000,
  parameter int unsigned DBL_GAP_US = 300,
  parameter int unsigned US_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            level_in,
  input  logic            qual_pulse,
`ifdef PRESS_CLASSIFIER_OVF_EN
  input  logic            ovf_clr,
  output logic            evt_ovf,
`endif
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_code,
  output logic [US_W-1:0] evt_hold_us
);

  localparam logic [US_W-1:0] HOLD_MAX = '1;

  state_e          state_q, state_d;
  logic [US_W-1:0] hold_q, hold_d;
  logic [US_W-1:0] hold1_q, hold1_d;
  logic [US_W-1:0] gap_q, gap_d;

  logic            tick;
  logic            tick_clr;
  logic            hold_long;
  logic            gap_done;
  logic [US_W-1:0] hold_inc;

  logic            emit;
  logic [1:0]      emit_code;
  logic [US_W-1:0] emit_hold;

  logic            evt_valid_q, evt_valid_d;
  logic [1:0]      evt_code_q, evt_code_d;
  logic [US_W-1:0] evt_hold_q, evt_hold_d;

  // every state entry restarts the microsecond so counts align to the entry cycle
  assign tick_clr = (state_d != state_q);

  us_tick_gen #(
    .CNT_1US(CNT_1US)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  // comparisons done at 32 bits so thresholds wider than the counters stay correct
  assign hold_long = (32'(hold_q) >= LONG_US);
  assign gap_done  = tick && ((32'(gap_q) + 32'd1) >= DBL_GAP_US);
  assign hold_inc  = (hold_q == HOLD_MAX) ? hold_q : hold_q + US_W'(1);

  // press state machine: next state, counters and the one-cycle emit request
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hold1_d   = hold1_q;
    gap_d     = gap_q;
    emit      = 1'b0;
    emit_code = EVT_NONE;
    emit_hold = '0;
    case (state_q)
      IDLE: begin
        if (qual_pulse) begin
          state_d = HELD;
          hold_d  = US_W'(1);
        end
      end
      HELD: begin
        if (!level_in) begin
          if (hold_long) begin
            emit      = 1'b1;
            emit_code = EVT_LONG;
            emit_hold = hold_q;
            state_d   = IDLE;
            hold_d    = '0;
          end else begin
            hold1_d = hold_q;
            gap_d   = '0;
            state_d = GAP;
          end
        end else if (tick) begin
          hold_d = hold_inc;
        end
      end
      GAP: begin
        // a second press beats a timeout landing in the same cycle
        if (qual_pulse) begin
          state_d = HELD2;
          hold_d  = US_W'(1);
        end else if (gap_done) begin
          emit      = 1'b1;
          emit_code = EVT_SHORT;
          emit_hold = hold1_q;
          state_d   = IDLE;
          gap_d     = '0;
          hold_d    = '0;
        end else if (tick) begin
          gap_d = gap_q + US_W'(1);
        end
      end
      HELD2: begin
        if (!level_in) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          emit_hold = hold_q;
          state_d   = IDLE;
          hold_d    = '0;
          gap_d     = '0;
        end else if (tick) begin
          hold_d = hold_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // press state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      hold1_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hold1_q <= hold1_d;
      gap_q   <= gap_d;
    end
  end

  // one-entry output buffer: accept frees it, an emit into a full unaccepted buffer is lost
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_hold_d  = evt_hold_q;
    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    if (emit && (!evt_valid_q || evt_ready)) begin
      evt_valid_d = 1'b1;
      evt_code_d  = emit_code;
      evt_hold_d  = emit_hold;
    end
  end

  // output buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_NONE;
      evt_hold_q  <= '0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_hold_q  <= evt_hold_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_hold_us = evt_hold_q;

`ifdef PRESS_CLASSIFIER_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_set;

  assign ovf_set = emit && evt_valid_q && !evt_ready;

  // sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // drop flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign evt_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - self-checking bench for press_classifier
module tb_press_classifier;

  localparam int unsigned N     = 10;
  localparam int unsigned LONG  = 20;
  localparam int unsigned GAPUS = 5;
  localparam int unsigned W     = 16;

  localparam logic [1:0] C_SHORT  = 2'b01;
  localparam logic [1:0] C_LONG   = 2'b10;
  localparam logic [1:0] C_DOUBLE = 2'b11;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         level_in   = 1'b0;
  logic         qual_pulse = 1'b0;
  logic         evt_ready  = 1'b1;
  logic         evt_valid;
  logic [1:0]   evt_code;
  logic [W-1:0] evt_hold_us;
`ifdef PRESS_CLASSIFIER_OVF_EN
  logic         ovf_clr    = 1'b0;
  logic         evt_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [W+1:0] evq[$];
  logic [W+1:0] expq[$];

  press_classifier #(
    .CNT_1US   (N),
    .LONG_US   (LONG),
    .DBL_GAP_US(GAPUS),
    .US_W      (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .level_in   (level_in),
    .qual_pulse (qual_pulse),
`ifdef PRESS_CLASSIFIER_OVF_EN
    .ovf_clr    (ovf_clr),
    .evt_ovf    (evt_ovf),
`endif
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_hold_us(evt_hold_us)
  );

  always #5 clk = ~clk;

  // record every accepted event
  always @(negedge clk) begin
    if (evt_valid && evt_ready) evq.push_back({evt_code, evt_hold_us});
  end

  function automatic int unsigned hold_of(input int unsigned cyc);
    return 1 + cyc / N;
  endfunction

  function automatic logic [W+1:0] ev(input logic [1:0] c, input int unsigned h);
    return {c, W'(h)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // level rises, the qualifier fires CNT_1US cycles later
  task automatic qualify();
    level_in = 1'b1;
    step(N - 1);
    qual_pulse = 1'b1;
    step(1);
    qual_pulse = 1'b0;
  endtask

  task automatic hold_high(input int n);
    level_in = 1'b1;
    step(n);
  endtask

  task automatic release_level();
    level_in = 1'b0;
    step(1);
  endtask

  task automatic wait_valid(input int max_cyc, output int lat);
    lat = 0;
    while (evt_valid !== 1'b1 && lat < max_cyc) begin
      step(1);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
    n_cmp++; if (evt_code !== 2'b00) begin n_bad++; $display("FAIL reset_code: got %0b want 00", evt_code); end
    n_cmp++; if (evt_hold_us !== '0) begin n_bad++; $display("FAIL reset_hold: got %0d want 0", evt_hold_us); end
`ifdef PRESS_CLASSIFIER_OVF_EN
    n_cmp++; if (evt_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0b want 0", evt_ovf); end
`endif
    rst_n = 1'b1;
    step(2);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %0b want 0", evt_valid); end
  endtask

  task automatic test_short();
    int lat;
    evq.delete();
    qualify(); hold_high(35); release_level();
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL short_early: got %0b want 0", evt_valid); end
    wait_valid(200, lat);
    n_cmp++; if (lat != int'(GAPUS * N)) begin n_bad++; $display("FAIL short_latency: got %0d want %0d", lat, GAPUS * N); end
    n_cmp++; if (evt_code !== C_SHORT) begin n_bad++; $display("FAIL short_code: got %0b want 01", evt_code); end
    n_cmp++; if (evt_hold_us !== W'(4)) begin n_bad++; $display("FAIL short_hold: got %0d want 4", evt_hold_us); end
    step(1);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL short_accept: got %0b want 0", evt_valid); end
    n_cmp++; if (evq.size() != 1) begin n_bad++; $display("FAIL short_count: got %0d want 1", evq.size()); end
  endtask

  task automatic test_long();
    qualify(); hold_high(250);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL long_early: got %0b want 0", evt_valid); end
    release_level();
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL long_valid: got %0b want 1", evt_valid); end
    n_cmp++; if (evt_code !== C_LONG) begin n_bad++; $display("FAIL long_code: got %0b want 10", evt_code); end
    n_cmp++; if (evt_hold_us !== W'(26)) begin n_bad++; $display("FAIL long_hold: got %0d want 26", evt_hold_us); end
    step(1);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL long_accept: got %0b want 0", evt_valid); end
  endtask

  task automatic test_double();
    evq.delete();
    qualify(); hold_high(35); release_level();
    step(20 - (N - 1));
    qualify(); hold_high(15); release_level();
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL double_valid: got %0b want 1", evt_valid); end
    n_cmp++; if (evt_code !== C_DOUBLE) begin n_bad++; $display("FAIL double_code: got %0b want 11", evt_code); end
    n_cmp++; if (evt_hold_us !== W'(2)) begin n_bad++; $display("FAIL double_hold: got %0d want 2", evt_hold_us); end
    step(GAPUS * N + 20);
    n_cmp++; if (evq.size() != 1) begin n_bad++; $display("FAIL double_count: got %0d want 1", evq.size()); end
  endtask

  task automatic test_glitch();
    int lat;
    qualify(); hold_high(35); release_level();
    step(10);
    level_in = 1'b1;
    step(5);
    level_in = 1'b0;
    wait_valid(200, lat);
    n_cmp++; if (lat != int'(GAPUS * N - 15)) begin n_bad++; $display("FAIL glitch_latency: got %0d want %0d", lat, GAPUS * N - 15); end
    n_cmp++; if (evt_code !== C_SHORT) begin n_bad++; $display("FAIL glitch_code: got %0b want 01", evt_code); end
    n_cmp++; if (evt_hold_us !== W'(4)) begin n_bad++; $display("FAIL glitch_hold: got %0d want 4", evt_hold_us); end
    step(1);
  endtask

  task automatic test_gap_boundary();
    // second press lands on the timeout cycle: still a double
    evq.delete();
    qualify(); hold_high(35); release_level();
    step(GAPUS * N - 1 - (N - 1));
    qualify(); hold_high(15); release_level();
    n_cmp++; if (evt_code !== C_DOUBLE || evt_valid !== 1'b1) begin n_bad++; $display("FAIL gap_edge_double: got v=%0b c=%0b want v=1 c=11", evt_valid, evt_code); end
    step(GAPUS * N + 20);
    // one cycle later: short first, then a fresh press
    evq.delete();
    qualify(); hold_high(35); release_level();
    step(GAPUS * N - (N - 1));
    qualify(); hold_high(15); release_level();
    step(GAPUS * N + 20);
    n_cmp++; if (evq.size() != 2) begin n_bad++; $display("FAIL gap_late_count: got %0d want 2", evq.size()); end
    n_cmp++; if (evq[0] !== ev(C_SHORT, 4)) begin n_bad++; $display("FAIL gap_late_first: got %0h want %0h", evq[0], ev(C_SHORT, 4)); end
    n_cmp++; if (evq[1] !== ev(C_SHORT, 2)) begin n_bad++; $display("FAIL gap_late_second: got %0h want %0h", evq[1], ev(C_SHORT, 2)); end
  endtask

  task automatic test_backpressure();
    evq.delete();
    evt_ready = 1'b0;
    qualify(); hold_high(250); release_level();
    n_cmp++; if (evt_valid !== 1'b1 || evt_code !== C_LONG || evt_hold_us !== W'(26)) begin n_bad++; $display("FAIL bp_first: got v=%0b c=%0b h=%0d want v=1 c=10 h=26", evt_valid, evt_code, evt_hold_us); end
    step(10);
    n_cmp++; if (evt_valid !== 1'b1 || evt_code !== C_LONG || evt_hold_us !== W'(26)) begin n_bad++; $display("FAIL bp_stable: got v=%0b c=%0b h=%0d want v=1 c=10 h=26", evt_valid, evt_code, evt_hold_us); end
    qualify(); hold_high(200); release_level();
    n_cmp++; if (evt_valid !== 1'b1 || evt_code !== C_LONG || evt_hold_us !== W'(26)) begin n_bad++; $display("FAIL bp_drop: got v=%0b c=%0b h=%0d want v=1 c=10 h=26", evt_valid, evt_code, evt_hold_us); end
`ifdef PRESS_CLASSIFIER_OVF_EN
    n_cmp++; if (evt_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b want 1", evt_ovf); end
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    n_cmp++; if (evt_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %0b want 0", evt_ovf); end
    qualify(); hold_high(200);
    ovf_clr = 1'b1; release_level(); ovf_clr = 1'b0;
    n_cmp++; if (evt_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %0b want 1", evt_ovf); end
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    n_cmp++; if (evt_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr2: got %0b want 0", evt_ovf); end
`endif
    // accept of the old event in the same cycle as a new emit
    qualify(); hold_high(220);
    evt_ready = 1'b1;
    release_level();
    n_cmp++; if (evt_valid !== 1'b1 || evt_code !== C_LONG || evt_hold_us !== W'(23)) begin n_bad++; $display("FAIL bp_swap: got v=%0b c=%0b h=%0d want v=1 c=10 h=23", evt_valid, evt_code, evt_hold_us); end
    step(1);
    n_cmp++; if (evq.size() != 2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", evq.size()); end
    n_cmp++; if (evq[0] !== ev(C_LONG, 26) || evq[1] !== ev(C_LONG, 23)) begin n_bad++; $display("FAIL bp_order: got %0h %0h want %0h %0h", evq[0], evq[1], ev(C_LONG, 26), ev(C_LONG, 23)); end
  endtask

  task automatic test_reset_mid();
    evq.delete();
    qualify(); hold_high(50);
    rst_n = 1'b0;
    step(3);
    n_cmp++; if (evt_valid !== 1'b0 || evt_code !== 2'b00 || evt_hold_us !== '0) begin n_bad++; $display("FAIL midrst_outputs: got v=%0b c=%0b h=%0d want 0 00 0", evt_valid, evt_code, evt_hold_us); end
    rst_n = 1'b1;
    step(1);
    level_in = 1'b0;
    step(80);
    n_cmp++; if (evq.size() != 0 || evt_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_silent: got n=%0d v=%0b want n=0 v=0", evq.size(), evt_valid); end
    qualify(); hold_high(250); release_level();
    n_cmp++; if (evt_valid !== 1'b1 || evt_code !== C_LONG || evt_hold_us !== W'(26)) begin n_bad++; $display("FAIL midrst_next: got v=%0b c=%0b h=%0d want v=1 c=10 h=26", evt_valid, evt_code, evt_hold_us); end
    step(1);
  endtask

  task automatic test_random();
    int unsigned h1, h2, g;
    bit second;
    evq.delete();
    expq.delete();
    for (int i = 0; i < 24; i++) begin
      h1 = $urandom_range(0, 260);
      h2 = $urandom_range(0, 260);
      g  = $urandom_range(N - 1, 60);
      second = ($urandom_range(0, 3) != 0);
      qualify(); hold_high(int'(h1)); release_level();
      if (hold_of(h1) >= LONG) begin
        expq.push_back(ev(C_LONG, hold_of(h1)));
      end else if (!second) begin
        expq.push_back(ev(C_SHORT, hold_of(h1)));
      end else begin
        step(int'(g - (N - 1)));
        qualify(); hold_high(int'(h2)); release_level();
        if (g <= GAPUS * N - 1) begin
          expq.push_back(ev(C_DOUBLE, hold_of(h2)));
        end else begin
          expq.push_back(ev(C_SHORT, hold_of(h1)));
          if (hold_of(h2) >= LONG) expq.push_back(ev(C_LONG, hold_of(h2)));
          else expq.push_back(ev(C_SHORT, hold_of(h2)));
        end
      end
      step(GAPUS * N + 20);
    end
    n_cmp++; if (evq.size() != expq.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", evq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      n_cmp++;
      if (evq[i] !== expq[i]) begin n_bad++; $display("FAIL rand_event[%0d]: got %0h want %0h", i, evq[i], expq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_glitch();
    test_gap_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/press_classifier.md
# press_classifier

Downstream consumer of the 1 µs pulse-width qualifier. It takes that stage's one-cycle qualified-press strobe together with the same synchronous input level, measures how long each press is held in whole microseconds, and classifies it as a short, long or double press. Each classified event is delivered through a one-entry valid/ready output buffer to the control logic.

## Interface
- CNT_1US, 100: clk cycles per microsecond (100 MHz clk); must match the qualifier's count.
- LONG_US, 1000: a hold of at least this many µs is a long press.
- DBL_GAP_US, 300: release gap in µs within which a second press makes a double press.
- US_W, 16: width of the µs hold and gap counters.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- level_in  in  1  synchronous input level; the same signal that feeds the qualifier.
- qual_pulse  in  1  one-cycle strobe from the qualifier; the level has been high for CNT_1US cycles.
- evt_valid  out  1  event present in the output buffer.
- evt_ready  in  1  consumer accepts the event when evt_valid and evt_ready are both high.
- evt_code  out  2  01 short, 10 long, 11 double, 00 never valid.
- evt_hold_us  out  US_W  measured hold in µs; for a double press, the hold of the second press.

## Operation
- Microsecond tick: a prescaler counts 0..CNT_1US-1 and pulses tick when it reaches CNT_1US-1. The prescaler clears on every state entry.
- States: IDLE, HELD, GAP, HELD2.
- IDLE: qual_pulse goes to HELD and sets hold_us=1. A low level_in is ignored.
- HELD:
  - Each tick increments hold_us, saturating at 2^US_W-1. qual_pulse is ignored.
  - When level_in is sampled low and hold_us>=LONG_US, emit LONG with hold_us and go to IDLE.
  - When level_in is sampled low and hold_us<LONG_US, latch hold1=hold_us, set gap_us=0 and go to GAP.
- GAP:
  - Each tick increments gap_us.
  - qual_pulse goes to HELD2 and sets hold_us=1.
  - When gap_us reaches DBL_GAP_US, emit SHORT with hold1 and go to IDLE.
  - Highs on level_in shorter than CNT_1US cycles produce no qual_pulse and are ignored.
  - If qual_pulse and the gap timeout occur in the same cycle, qual_pulse wins.
- HELD2: hold_us counts as in HELD. When level_in is sampled low, emit DOUBLE with hold_us (regardless of LONG_US) and go to IDLE.
- Output buffer:
  - Emit loads evt_code and evt_hold_us and sets evt_valid.
  - An accept clears evt_valid.
  - If an emit coincides with an accept, the new event loads.
  - If an emit occurs while evt_valid=1 and evt_ready=0, the new event is dropped and the buffered event stays stable.
- Reset (at any time, including mid-press): state IDLE, all counters 0, evt_valid=0, evt_code=00, evt_hold_us=0.

## Timing
- hold_us = 1 + floor(cycles spent in HELD or HELD2 / CNT_1US).
- LONG and DOUBLE: evt_valid rises the cycle after level_in is first sampled low.
- SHORT: evt_valid rises the cycle after the tick that brings gap_us to DBL_GAP_US.
- evt_code and evt_hold_us hold constant while evt_valid=1 and the event is not accepted.
- No combinational path from inputs to outputs.

## Configuration
- PRESS_CLASSIFIER_OVF_EN defined:
  - Adds input ovf_clr (1) and output evt_ovf (1, reset 0).
  - evt_ovf is set sticky on every dropped event and cleared by an ovf_clr pulse.
  - If a set and a clear occur in the same cycle, the set wins.
- PRESS_CLASSIFIER_OVF_EN undefined: those ports are absent and drops are silent.

## Structure
- press_classifier_pkg holds:
  - the state enum (IDLE/HELD/GAP/HELD2);
  - the event code constants EVT_SHORT=2'b01, EVT_LONG=2'b10, EVT_DOUBLE=2'b11.
- Sub-module us_tick_gen: the CNT_1US prescaler with a synchronous clear and a tick output.

## Test plan
Bench parameters: CNT_1US=10, LONG_US=20, DBL_GAP_US=5.
- Short press: qual_pulse, 35 cycles in HELD, release -> after 5 µs gap, evt_valid with code 01, hold 4.
- Long press: qual_pulse, 250 cycles in HELD, release -> next cycle code 10, hold 26.
- Double press: hold 4, 20-cycle gap, qual_pulse, 15 cycles in HELD2, release -> code 11, hold 2; no SHORT emitted.
- Glitch in gap: 5-cycle high with no qual_pulse during GAP -> ignored; SHORT hold 4 still emitted at timeout.
- Backpressure: evt_ready=0 through two events -> first event stays stable, second is dropped; evt_ovf=1 with macro; ovf_clr -> 0.
- Reset mid-HELD: rst_n low for 3 cycles, then release the level -> evt_valid stays 0; the next press classifies normally.
